// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add step (two half-adders plus an OR) per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  a_sh;
   logic [WIDTH-1:0]  b_sh;
   logic [WIDTH-2:0]  sum_sh;
   logic              carry;

   logic              ha0_s;
   logic              ha0_c;
   logic              bit_s;
   logic              bit_c;
   logic              last_bit;
   logic [WIDTH-1:0]  sum_nxt;
   logic [WIDTH-1:0]  b_load;
   logic              carry_init;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert B and seed the carry with 1.
   assign b_load     = sub ? ~b : b;
   assign carry_init = sub;
`else
   assign b_load     = b;
   assign carry_init = 1'b0;
`endif

   assign ha0_s    = a_sh[0] ^ b_sh[0];
   assign ha0_c    = a_sh[0] & b_sh[0];
   assign bit_s    = ha0_s ^ carry;
   assign bit_c    = ha0_c | (ha0_s & carry);
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   // Shadow holds the upper WIDTH-1 bits; the new bit enters at the MSB.
   assign sum_nxt  = {bit_s, sum_sh};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  carry <= carry_init;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= bit_c;
               cnt    <= cnt + CNT_W'(1);
               sum_sh <= sum_nxt[WIDTH-1:1];
               // Visible result changes only on the edge that enters DONE.
               if (last_bit) begin
                  sum  <= sum_nxt;
                  cout <= bit_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): expected {cout,sum} queued at issue,
// popped and compared by a monitor whenever done is seen.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   logic [W:0]   exp_q[$];
   int           n_cmp;
   int           n_err;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got {cout,sum}=0x%0h expected no done", {cout, sum});
         end else begin
            check("result", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   // waits at negedges until done; lat counts negedges since the one after acceptance
   task automatic wait_done(output int lat, output int bcnt, input int lat0);
      lat  = lat0;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   // driver: issue one op in an IDLE cycle, then scramble operands after capture
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic [W:0] exp, input string name);
      int lat;
      int bcnt;
      a     = ta;
      b     = tb_v;
      sub   = ts;
      start = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom_range(0, 1));
      wait_done(lat, bcnt, 1);
      check({name, "_latency"}, lat, W + 1);
      check({name, "_busy_cycles"}, bcnt, W);
      @(negedge clk);
      check({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
      check({name, "_held"}, {23'd0, cout, sum}, {23'd0, exp});
   endtask

   initial begin
      int lat;
      int bcnt;
      int idle_bad;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sub   = 1'b0;
      #3;
      check("reset_outputs", {21'd0, busy, done, cout, sum}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // idle with no start: nothing moves
      idle_bad = 0;
      a = 8'h5A;
      b = 8'h33;
      repeat (6) begin
         @(negedge clk);
         if (busy || done || sum != 0 || cout) idle_bad++;
      end
      check("idle_no_activity", idle_bad, 0);

      // basic add, then outputs hold
      run_op(8'h05, 8'h03, 1'b0, 9'h008, "add_5_3");
      repeat (3) @(negedge clk);
      check("hold_after_idle", {23'd0, cout, sum}, 32'h008);

      run_op(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
      run_op(8'h80, 8'h80, 1'b0, 9'h100, "add_80_80");
      run_op(8'hAA, 8'h55, 1'b0, 9'h0FF, "add_aa_55");
      run_op(8'hFF, 8'hFF, 1'b0, 9'h1FE, "add_ff_ff");
      run_op(8'h00, 8'h00, 1'b0, 9'h000, "add_00_00");

      // start during busy is ignored; restart in first IDLE cycle is accepted
      a     = 8'h10;
      b     = 8'h20;
      start = 1'b1;
      exp_q.push_back(9'h030);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a     = 8'h01;
      b     = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt, 4);
      check("ignored_start_latency", lat, W + 1);
      @(negedge clk);
      run_op(8'h03, 8'h04, 1'b0, 9'h007, "restart_in_idle");

      // reset mid-operation aborts with no done
      a     = 8'h7F;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_reset_outputs", {21'd0, busy, done, cout, sum}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_bad = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (busy || done) idle_bad++;
      end
      check("no_activity_after_abort", idle_bad, 0);
      run_op(8'h02, 8'h02, 1'b0, 9'h004, "add_after_abort");

`ifdef SERIAL_ADDER_SUB_EN
      run_op(8'h05, 8'h03, 1'b1, 9'h102, "sub_5_3");
      run_op(8'h03, 8'h05, 1'b1, 9'h0FE, "sub_3_5");
      run_op(8'h40, 8'h40, 1'b1, 9'h100, "sub_equal");
      run_op(8'h05, 8'h03, 1'b0, 9'h008, "sub_off_add");
`endif

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
